// File: rtl/fnd_pkg.sv
// Shared constants for the 7-segment time display: segment codes,
// digit codes fed to the decoder, and field positions in the time word.
package fnd_pkg;

  localparam int NUM_DIGITS = 4;

  // Time word layout: {hour, min, sec, msec}, 8 bits each.
  localparam int FIELD_W  = 8;
  localparam int HOUR_LSB = 24;
  localparam int MIN_LSB  = 16;
  localparam int SEC_LSB  = 8;
  localparam int MSEC_LSB = 0;

  // Active-low segment codes, bit order {dp,g,f,e,d,c,b,a}, dp off.
  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_DASH  = 8'hBF;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Digit codes understood by the decoder besides 0..9.
  localparam logic [3:0] CODE_DASH  = 4'd10;
  localparam logic [3:0] CODE_BLANK = 4'd15;

  // Out-of-range fields (>= 100) cannot be shown as two decimals, so both
  // of their digits turn into dashes.
  function automatic logic [3:0] tens_code(input logic [FIELD_W-1:0] v);
    if (v >= 8'd100) return CODE_DASH;
    return 4'(v / 8'd10);
  endfunction

  function automatic logic [3:0] ones_code(input logic [FIELD_W-1:0] v);
    if (v >= 8'd100) return CODE_DASH;
    return 4'(v % 8'd10);
  endfunction

endpackage

// File: rtl/fnd_seg_decoder.sv
// Digit code (0..9, 10 = dash, anything else = blank) to active-low
// segments {g,f,e,d,c,b,a}. The decimal point is handled by the caller.
module fnd_seg_decoder
  import fnd_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] seg
);

  // Pure lookup; unknown codes blank the digit.
  always_comb begin
    seg = SEG_BLANK[6:0];
    case (code)
      4'd0:      seg = SEG_0[6:0];
      4'd1:      seg = SEG_1[6:0];
      4'd2:      seg = SEG_2[6:0];
      4'd3:      seg = SEG_3[6:0];
      4'd4:      seg = SEG_4[6:0];
      4'd5:      seg = SEG_5[6:0];
      4'd6:      seg = SEG_6[6:0];
      4'd7:      seg = SEG_7[6:0];
      4'd8:      seg = SEG_8[6:0];
      4'd9:      seg = SEG_9[6:0];
      CODE_DASH: seg = SEG_DASH[6:0];
      default:   seg = SEG_BLANK[6:0];
    endcase
  end

endmodule

// File: rtl/fnd_time_display.sv
// 4-digit multiplexed 7-segment driver for the packed time bus.
// A snapshot of the time word is taken once per frame (on the index 3->0
// step) so all four digits of a frame agree. fnd_com/fnd_data are
// registered one cycle behind the digit index. No handshake: the time bus
// is sampled level-wise, and outputs are valid whenever rst is low.
module fnd_time_display
  import fnd_pkg::*;
#(
  parameter int CLK_FREQ = 100_000_000,
  parameter int SCAN_HZ  = 1000,
  parameter int BLINK_HZ = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_time_data,
  input  logic        i_disp_sel,
  input  logic [3:0]  i_blink_mask,
  output logic [3:0]  fnd_com,
  output logic [7:0]  fnd_data
);

  localparam int SCAN_DIV  = CLK_FREQ / SCAN_HZ;
  localparam int BLINK_DIV = CLK_FREQ / (2 * BLINK_HZ);
  localparam int SCAN_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BLINK_W   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [SCAN_W-1:0]  scan_cnt;
  logic               scan_tick;
  logic [1:0]         idx;
  logic [31:0]        snap_time;
  logic               snap_sel;
  logic [BLINK_W-1:0] blink_cnt;
  logic               blink_wrap;
  logic               blink_on;

  logic [FIELD_W-1:0] hi_val;
  logic [FIELD_W-1:0] lo_val;
  logic [FIELD_W-1:0] snap_msec;
  logic [3:0]         digit_code;
  logic [6:0]         seg;
  logic               dp_n;
  logic               blank;

  assign scan_tick  = (scan_cnt == SCAN_W'(SCAN_DIV - 1));
  assign blink_wrap = (blink_cnt == BLINK_W'(BLINK_DIV - 1));

  // Scan divider: one tick per digit period.
  always_ff @(posedge clk) begin
    if (rst || scan_tick) scan_cnt <= '0;
    else                  scan_cnt <= scan_cnt + 1'b1;
  end

  // Digit index 0->1->2->3->0, advanced by the scan tick.
  always_ff @(posedge clk) begin
    if (rst)            idx <= 2'd0;
    else if (scan_tick) idx <= idx + 2'd1;
  end

  // Frame snapshot, loaded on the same edge the index wraps to 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      snap_time <= '0;
      snap_sel  <= 1'b0;
    end else if (scan_tick && (idx == 2'd3)) begin
      snap_time <= i_time_data;
      snap_sel  <= i_disp_sel;
    end
  end

  // Free-running blink half-period counter and phase flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (blink_wrap) begin
      blink_cnt <= '0;
      blink_on  <= ~blink_on;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  // Field pair selection and per-index digit code from the snapshot.
  always_comb begin
    snap_msec = snap_time[MSEC_LSB +: FIELD_W];
    if (snap_sel) begin
      hi_val = snap_time[HOUR_LSB +: FIELD_W];
      lo_val = snap_time[MIN_LSB +: FIELD_W];
    end else begin
      hi_val = snap_time[SEC_LSB +: FIELD_W];
      lo_val = snap_msec;
    end
    case (idx)
      2'd0:    digit_code = ones_code(lo_val);
      2'd1:    digit_code = tens_code(lo_val);
      2'd2:    digit_code = ones_code(hi_val);
      default: digit_code = tens_code(hi_val);
    endcase
    // Half-second indicator: dp on digit 2 during the first half second.
    dp_n  = ~((idx == 2'd2) && (snap_msec < 8'd50));
    // Mask is taken live so setting mode reacts immediately.
    blank = ~blink_on && i_blink_mask[idx];
  end

  fnd_seg_decoder u_dec (
    .code (digit_code),
    .seg  (seg)
  );

  // Registered outputs: one-cold digit enable and segment pattern.
  always_ff @(posedge clk) begin
    if (rst) begin
      fnd_com  <= 4'b1111;
      fnd_data <= SEG_BLANK;
    end else begin
      fnd_com  <= ~(4'b0001 << idx);
      fnd_data <= blank ? SEG_BLANK : {dp_n, seg};
    end
  end

endmodule

// File: doc/fnd_time_display.md
# fnd_time_display

Downstream display stage for the stopwatch/watch time bus. It consumes the packed 32-bit time word `{hour, min, sec, msec}` (8 bits per field) and converts the selected field pair to decimal digits. It drives a 4-digit common-anode 7-segment display through time-multiplexed scanning. It also provides a per-digit blink for watch setting and a half-second decimal-point indicator.

## Interface
Parameters:
- `CLK_FREQ`, 100_000_000 — clock frequency in Hz.
- `SCAN_HZ`, 1000 — digit-advance rate in Hz; `SCAN_DIV = CLK_FREQ/SCAN_HZ`.
- `BLINK_HZ`, 2 — blink rate in Hz; half-period `BLINK_DIV = CLK_FREQ/(2*BLINK_HZ)`.

Ports:
- `clk` in 1 — single clock.
- `rst` in 1 — reset. **Synchronous, active-high.**
- `i_time_data` in 32 — `[31:24]` hour, `[23:16]` min, `[15:8]` sec, `[7:0]` msec (centiseconds).
- `i_disp_sel` in 1 — 0: sec.msec; 1: hour.min.
- `i_blink_mask` in 4 — bit n set: digit n blanks during the blink-off phase.
- `fnd_com` out 4 — digit enables, active-low. Bit 0 is the rightmost digit.
- `fnd_data` out 8 — segments, active-low, bit order `{dp,g,f,e,d,c,b,a}`.

## Operation
**Scan tick**
- Counter runs 0..`SCAN_DIV`-1.
- `scan_tick` pulses for 1 cycle when the counter equals `SCAN_DIV`-1; the counter then wraps to 0.

**Digit index**
- 2-bit index advances on `scan_tick`: 0→1→2→3→0.

**Frame snapshot**
- On the `scan_tick` that moves the index 3→0, register `i_time_data` and `i_disp_sel` into a snapshot.
- All digit values in a frame come from that snapshot. No tearing within a frame.

**Field pair**
- sel=0: hi=sec, lo=msec.
- sel=1: hi=hour, lo=min.

**Digit values**
- Digit 3 = hi/10, digit 2 = hi%10, digit 1 = lo/10, digit 0 = lo%10.
- Any field value ≥100 shows dash on both of its digits.

**Segment codes**
- Digits 0–9: C0,F9,A4,B0,99,92,82,F8,80,90.
- Dash: BF. Blank: FF.

**Decimal point**
- Lit (bit7=0) on digit 2 only, when snapshot msec < 50.
- Otherwise dp is off; dp is always off on digits 3, 1, 0.
- If msec ≥100, dp is off.

**Blink**
- Free-running counter 0..`BLINK_DIV`-1. On wrap it toggles `blink_on`; `blink_on` is 1 after reset.
- When `blink_on`=0 and `i_blink_mask[idx]`=1, `fnd_data`=FF (dp included).
- `fnd_com` still selects that digit.
- `i_blink_mask` is sampled live, not snapshotted.

**Selection**
- `fnd_com` = one-cold of the index: idx0→1110, idx1→1101, idx2→1011, idx3→0111.

## Timing
**Reset**
- On `rst`=1 at a clock edge: `fnd_com`=1111, `fnd_data`=FF, scan counter 0, index 0, snapshot 0 (sel 0), blink counter 0, `blink_on`=1.
- After reset release, the first displayed value is 00.00 (digit 0 first), with dp lit because msec=0<50.
- Reset mid-frame takes effect on the same edge and is blocking: outputs hold reset values while `rst`=1.

**Output registers**
- `fnd_com` and `fnd_data` are registered.
- They update 1 cycle after the index register changes: index at edge k, outputs at edge k+1.
- While the index is stable, outputs are stable.
- First valid drive is 1 cycle after the first post-reset edge.

**Input latency**
- An `i_time_data` change becomes visible no later than one full frame (4·`SCAN_DIV` cycles) plus 2 cycles.

**Boundary conditions**
- Snapshot load and index wrap occur on the same edge. Digit 0 of the new frame uses the new snapshot.
- A `blink_on` toggle coinciding with `scan_tick`: both take effect, and outputs reflect both on the next edge.
- `i_disp_sel` change mid-frame: no effect until the next frame.
- Hour field upper bits: no saturation logic. Only the ≥100 dash rule applies.

## Structure
**Package `fnd_pkg`**
- Segment constants `SEG_0`..`SEG_9`, `SEG_DASH`, `SEG_BLANK`.
- `NUM_DIGITS`=4.
- Field bit positions in the 32-bit time word.

**Sub-module `fnd_seg_decoder`**
- Combinational: 4-bit digit code (0–9, 10=dash, 15=blank) → 7 segment bits.
- Instantiated once on the muxed digit.

**Top level**
- Holds the scan/blink counters, index, snapshot, digit split, and output registers.

## Test plan
Sim params: `CLK_FREQ`=1000, `SCAN_HZ`=100 (`SCAN_DIV`=10), `BLINK_HZ`=10 (`BLINK_DIV`=50).

1. **Reset:** assert `rst` 3 cycles → `fnd_com`=1111, `fnd_data`=FF. Release → first frame shows C0,C0,40(digit2, dp),C0 on com 1110/1101/1011/0111.
2. **sec.msec display:** `i_time_data`=0C1E2D07 (12:30:45.07), sel=0, one frame settled.
   - Digits 3..0 = 99, 12, C0, F8.
   - Digit 2 dp lit because 7<50.
3. **hour.min display:** same data, sel=1 → digits 3..0 = F9, A4, B0, C0. With msec=0x3C (60), digit 2 = A4 (dp off).
4. **Dash rule:** sec=0x64, sel=0 → digits 3 and 2 = BF, BF; digits 1 and 0 from msec.
5. **Snapshot:** change `i_time_data` while index=1 → digits 1..3 of the current frame are unchanged. The new value appears from the next index-0 digit.
6. **Blink:** `i_blink_mask`=1100.
   - For cycles where `blink_on`=0 (50-cycle windows), digits 3 and 2 = FF while `fnd_com` still cycles.
   - Digits 1 and 0 are unaffected.
   - Assert `rst` inside an off window → `blink_on`=1 and outputs FF/1111 on the next edge.
